// File: rtl/csr_mtrap_unit.sv
// rtl/csr_mtrap_unit.sv - machine-mode CSR file with trap entry / mret sequencer
// Ports:
//   clk, rst_n                        core clock, asynchronous active-low reset
//   csr_req_i/op_i/addr_i/wdata_i     CSR instruction from execute (op 01 RW, 10 RS, 11 RC, 00 read)
//   csr_rdata_o, csr_illegal_o        combinational old value / illegal-access flag
//   exc_valid_i/cause_i/pc_i/tval_i   synchronous exception from the pipeline
//   mret_i                            mret retiring
//   irq_ok_i, irq_pc_i                interrupt acceptance window and its resume PC
//   irq_ext_i/timer_i/soft_i          level interrupt lines (mirrored in mip)
//   redirect_valid_o/pc_o             registered one-cycle fetch redirect
//   trap_taken_o                      registered; accompanies the redirect on trap entry only
module csr_mtrap_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [25:0]     MISA_EXT    = 26'h000_0100,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            csr_req_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            exc_valid_i,
   input  logic [4:0]      exc_cause_i,
   input  logic [XLEN-1:0] exc_pc_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic            mret_i,
   input  logic            irq_ok_i,
   input  logic [XLEN-1:0] irq_pc_i,
   input  logic            irq_ext_i,
   input  logic            irq_timer_i,
   input  logic            irq_soft_i,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            trap_taken_o
);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   // mtvec mode 1x is reserved; it collapses to direct mode
   function automatic logic [XLEN-1:0] f_mtvec_legal(input logic [XLEN-1:0] v);
      return {v[XLEN-1:2], 1'b0, v[0] & ~v[1]};
   endfunction

   localparam logic [1:0]      MXL             = (XLEN == 64) ? 2'd2 : 2'd1;
   localparam logic [XLEN-1:0] MTVEC_RST_LEGAL = f_mtvec_legal(MTVEC_RESET);

   state_t            r_state, w_state_next;
   logic              r_mstatus_mie, r_mstatus_mpie;
   logic [2:0]        r_mie;               // {MEIE, MTIE, MSIE}
   logic [XLEN-1:0]   r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [63:0]       r_mcycle;
   logic              r_redirect_valid, r_trap_taken;
   logic [XLEN-1:0]   r_redirect_pc;

   logic [XLEN-1:0]   w_mstatus, w_mip, w_mie_rd, w_rdata, w_wval;
   logic [XLEN-1:0]   w_mtvec_base, w_irq_target;
   logic [2:0]        w_pend;              // {MEI, MTI, MSI} pending and enabled
   logic [4:0]        w_irq_code;
   logic              w_hit, w_illegal;
   logic              w_take_exc, w_take_irq, w_take_mret, w_do_write;
   logic              w_wr_mcycle, w_wr_mcycleh;

   // MPP is hardwired to machine mode
   assign w_mstatus = XLEN'({2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000});
   assign w_mip     = XLEN'({irq_ext_i, 3'b000, irq_timer_i, 3'b000, irq_soft_i, 3'b000});
   assign w_mie_rd  = XLEN'({r_mie[2], 3'b000, r_mie[1], 3'b000, r_mie[0], 3'b000});
   assign w_pend    = {irq_ext_i & r_mie[2], irq_timer_i & r_mie[1], irq_soft_i & r_mie[0]};

   // MEI > MSI > MTI
   assign w_irq_code   = w_pend[2] ? 5'd11 : (w_pend[0] ? 5'd3 : 5'd7);
   assign w_mtvec_base = {r_mtvec[XLEN-1:2], 2'b00};
   assign w_irq_target = r_mtvec[0] ? (w_mtvec_base + XLEN'({w_irq_code, 2'b00})) : w_mtvec_base;

   always_comb begin
      w_hit   = 1'b1;
      w_rdata = '0;
      case (csr_addr_i)
         12'h300: w_rdata = w_mstatus;
         12'h301: w_rdata = {MXL, {(XLEN-28){1'b0}}, MISA_EXT};
         12'h304: w_rdata = w_mie_rd;
         12'h305: w_rdata = r_mtvec;
         12'h340: w_rdata = r_mscratch;
         12'h341: w_rdata = r_mepc;
         12'h342: w_rdata = r_mcause;
         12'h343: w_rdata = r_mtval;
         12'h344: w_rdata = w_mip;
         12'hB00: w_rdata = r_mcycle[XLEN-1:0];
         12'hB80: begin
            if (XLEN == 32) w_rdata = XLEN'(r_mcycle[63:32]);
            else            w_hit   = 1'b0;
         end
         12'hF11, 12'hF12, 12'hF13: w_rdata = '0;
         12'hF14: w_rdata = HART_ID;
         default: w_hit = 1'b0;
      endcase
   end

   assign w_illegal     = !w_hit || ((csr_addr_i[11:10] == 2'b11) && (csr_op_i != 2'b00));
   assign csr_rdata_o   = w_rdata;
   assign csr_illegal_o = w_illegal;

   always_comb begin
      case (csr_op_i)
         2'b01:   w_wval = csr_wdata_i;
         2'b10:   w_wval = w_rdata | csr_wdata_i;
         2'b11:   w_wval = w_rdata & ~csr_wdata_i;
         default: w_wval = w_rdata;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_take_exc   = 1'b0;
      w_take_irq   = 1'b0;
      w_take_mret  = 1'b0;
      w_do_write   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (exc_valid_i)                                w_take_exc  = 1'b1;
            else if (r_mstatus_mie && irq_ok_i && |w_pend)  w_take_irq  = 1'b1;
            else if (mret_i)                                w_take_mret = 1'b1;
            else if (csr_req_i && csr_op_i != 2'b00 && !w_illegal) w_do_write = 1'b1;
            if (w_take_exc || w_take_irq || w_take_mret)    w_state_next = S_FLUSH;
         end
         default: w_state_next = S_RUN;
      endcase
   end

   assign w_wr_mcycle  = w_do_write && (csr_addr_i == 12'hB00);
   assign w_wr_mcycleh = w_do_write && (csr_addr_i == 12'hB80);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_RUN;
      else        r_state <= w_state_next;
   end

   // A software write to either half freezes the whole counter for that cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_mcycle <= '0;
      else if (w_wr_mcycle)  r_mcycle[XLEN-1:0] <= w_wval;
      else if (w_wr_mcycleh) r_mcycle[63:32] <= w_wval[31:0];
      else                   r_mcycle <= r_mcycle + 64'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mstatus_mie    <= 1'b0;
         r_mstatus_mpie   <= 1'b0;
         r_mie            <= '0;
         r_mtvec          <= MTVEC_RST_LEGAL;
         r_mscratch       <= '0;
         r_mepc           <= '0;
         r_mcause         <= '0;
         r_mtval          <= '0;
         r_redirect_valid <= 1'b0;
         r_trap_taken     <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_take_exc | w_take_irq | w_take_mret;
         r_trap_taken     <= w_take_exc | w_take_irq;
         if (w_take_exc) begin
            r_mepc         <= {exc_pc_i[XLEN-1:1], 1'b0};
            r_mcause       <= XLEN'(exc_cause_i);
            r_mtval        <= exc_tval_i;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_redirect_pc  <= w_mtvec_base;
         end else if (w_take_irq) begin
            r_mepc         <= irq_pc_i;
            r_mcause       <= {1'b1, (XLEN-1)'(w_irq_code)};
            r_mtval        <= '0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_redirect_pc  <= w_irq_target;
         end else if (w_take_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
            r_redirect_pc  <= r_mepc;
         end else if (w_do_write) begin
            case (csr_addr_i)
               12'h300: begin
                  r_mstatus_mie  <= w_wval[3];
                  r_mstatus_mpie <= w_wval[7];
               end
               12'h304: r_mie      <= {w_wval[11], w_wval[7], w_wval[3]};
               12'h305: r_mtvec    <= f_mtvec_legal(w_wval);
               12'h340: r_mscratch <= w_wval;
               12'h341: r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
               12'h342: r_mcause   <= w_wval;
               12'h343: r_mtval    <= w_wval;
               default: ;
            endcase
         end
      end
   end

   assign redirect_valid_o = r_redirect_valid;
   assign redirect_pc_o    = r_redirect_pc;
   assign trap_taken_o     = r_trap_taken;

endmodule

// File: doc/csr_mtrap_unit.md
Name: csr_mtrap_unit

Overview:
- Machine-mode CSR file with trap sequencer; the register-level successor to the core's CSR type definitions.
- Holds misa, mvendorid, marchid, mimpid, mhartid, mstatus, mtvec, mie, mip, mscratch, mepc, mcause, mtval and mcycle[h].
- Sequences exception/interrupt entry and mret, and issues a registered PC redirect to fetch.
- Sits beside the execute stage.

Parameters:
- XLEN, 32, data width; 32 or 64 only. mcycleh exists only when XLEN=32.
- HART_ID, 0, constant read from mhartid.
- MISA_EXT, 26'h000_0100 (I), misa extensions field; mxl = 1 for XLEN=32, 2 for XLEN=64.
- MTVEC_RESET, 0, reset value of mtvec. Bits [1:0] are forced to legal.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_req_i  in  1  CSR instruction valid this cycle
- csr_op_i  in  2  01 RW, 10 RS, 11 RC, 00 read-only
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  rs1/uimm operand
- csr_rdata_o  out  XLEN  combinational old value of the addressed CSR
- csr_illegal_o  out  1  combinational: unimplemented address, or write to a read-only CSR (addr[11:10]==2'b11 with op!=00)
- exc_valid_i  in  1  synchronous exception from the pipeline
- exc_cause_i  in  5  exception code
- exc_pc_i  in  XLEN  PC of the faulting instruction
- exc_tval_i  in  XLEN  trap value
- mret_i  in  1  mret retiring
- irq_ok_i  in  1  pipeline can accept an interrupt at irq_pc_i
- irq_pc_i  in  XLEN  PC of the next unretired instruction
- irq_ext_i, irq_timer_i, irq_soft_i  in  1 each  level interrupt lines
- redirect_valid_o  out  1  registered; fetch redirect pulse
- redirect_pc_o  out  XLEN  registered target
- trap_taken_o  out  1  registered; pulse with redirect on trap entry (not mret)

Behaviour:
- Reset (async, rst_n low):
  - Outputs: redirect_valid_o, trap_taken_o = 0; redirect_pc_o = 0.
  - Registers: mstatus.MIE = 0, MPIE = 0, MPP = 2'b11; mtvec = MTVEC_RESET; mie = 0; mepc = mcause = mtval = mscratch = 0; mcycle = 0; FSM in RUN.
- Read-only fields: mip bits MEIP[11], MTIP[7], MSIP[3] mirror the inputs combinationally and are read-only. All other mip/mie bits read 0.
- FSM states RUN and FLUSH.
- RUN, evaluated each cycle in priority order:
  1. exc_valid_i
     - mepc = exc_pc_i with bit 0 cleared.
     - mcause = {0, exc_cause_i} zero-extended.
     - mtval = exc_tval_i.
     - MPIE = MIE; MIE = 0; MPP = 11.
     - Redirect to {mtvec.base, 2'b00} (vectored mode ignored for exceptions).
     - Go to FLUSH.
  2. Interrupt pending: MIE && irq_ok_i && (mip & mie) != 0.
     - Priority MEI > MSI > MTI; code 11, 3 or 7.
     - mcause = {1, code}; mepc = irq_pc_i; mtval = 0.
     - Same mstatus update as an exception.
     - Target: base if mode==00; base + 4*code if mode==01.
     - Go to FLUSH.
  3. mret_i
     - MIE = MPIE; MPIE = 1; MPP = 11.
     - Redirect to mepc. Go to FLUSH.
  4. csr_req_i, op != 00, not illegal
     - RW writes wdata; RS writes old | wdata; RC writes old & ~wdata.
     - WARL masks: mtvec.mode values 1x written as 00; mepc[1:0] = 0; mie keeps only bits 11, 7, 3; mstatus keeps only MIE, MPIE, MPP (MPP reads 11 always).
- Trap/mret takes precedence over a same-cycle CSR write; the write is dropped.
- redirect_valid_o (and trap_taken_o for cases 1–2) assert on the edge that enters FLUSH, for exactly 1 cycle.
- FLUSH: exc_valid_i, interrupt, mret_i and CSR writes are all ignored. Reads still return data. Unconditionally returns to RUN next cycle.
- mcycle:
  - 64-bit; +1 every cycle, wrapping from all-ones to 0.
  - Software write to mcycle (low XLEN bits) or mcycleh (upper 32 bits) replaces that part and suppresses the increment of the whole counter that cycle.
- Illegal access: csr_illegal_o = 1, no state change; the pipeline raises the exception.
- Reset mid-FLUSH: returns to RUN with redirect_valid_o = 0 immediately (async).
- Address map (standard): mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, mcycleh B80, mvendorid F11 (=0), marchid F12 (=0), mimpid F13 (=0), mhartid F14.

Test Plan:
- Reset, read 300/305/F14 with HART_ID=3 → 0x0000_1800, MTVEC_RESET, 3; redirect_valid_o = 0.
- RS 0x8 to mstatus, then exc_valid_i cause 2, pc 0x100, tval 0xDEAD → next cycle redirect_valid_o = 1 to mtvec base; mepc 0x100, mcause 2, mtval 0xDEAD, MIE = 0, MPIE = 1; mret → redirect 0x100, MIE = 1.
- mtvec = 0x1001 (vectored), mie = 0x888, MIE = 1, irq_timer_i + irq_ext_i, irq_ok_i → mcause 0x8000_000B, redirect 0x102C; with irq_ok_i = 0, no trap.
- Same-cycle exc_valid_i and CSR RW of mscratch=5 → trap taken, mscratch unchanged; next-cycle exception during FLUSH → ignored, single redirect pulse.
- Write mcycle = 0xFFFF_FFFF, mcycleh = 0 → after 2 cycles mcycleh reads 1, mcycle 0; write 0xFFFF_FFFF to mcycle while RC on F14 → csr_illegal_o = 1.
- Assert rst_n low during FLUSH → redirect_valid_o drops without clock; mstatus back to 0x1800.
